// File: rtl/regs_port_ctrl_if.sv
// Host request/response handshakes and register-file port of regs_port_ctrl.
// The slave modport is the controller's view; the master modport is the host/register-file side.
interface regs_port_ctrl_if #(
   parameter int n = 8
);
   logic         req_valid;
   logic         req_ready;
   logic         req_write;
   logic         req_addr;
   logic [n-1:0] req_wdata;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [n-1:0] rsp_data;
   logic         rsp_err;
   logic         rf_w;
   logic [n-1:0] rf_wdata;
   logic         rf_addr;
   logic [n-1:0] rf_rdata;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready, rf_rdata,
      output req_ready, rsp_valid, rsp_data, rsp_err, rf_w, rf_wdata, rf_addr
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready, rf_rdata,
      input  req_ready, rsp_valid, rsp_data, rsp_err, rf_w, rf_wdata, rf_addr
   );
endinterface

// File: rtl/regs_port_ctrl.sv
// Request-driven initiator for the two-entry picoMIPS register file (registered read port).
// Define REGS_VERIFY_EN to read back every write and flag a mismatch on rsp_err.
module regs_port_ctrl #(
   parameter int n = 8
) (
   input  logic            clk,
   input  logic            n_reset,
   regs_port_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      VREAD = 3'd2,
      CAPT  = 3'd3,
      RESP  = 3'd4
   } state_e;

   state_e       state_q, state_d;
   logic         req_ready_q, req_ready_d;
   logic         rsp_valid_q, rsp_valid_d;
   logic [n-1:0] rsp_data_q, rsp_data_d;
   logic         rf_w_q, rf_w_d;
   logic [n-1:0] rf_wdata_q, rf_wdata_d;
   logic         rf_addr_q, rf_addr_d;
   logic         write_q, write_d;
`ifdef REGS_VERIFY_EN
   logic         rsp_err_q, rsp_err_d;
`endif

   // Next-state and registered-output decode
   always_comb begin
      state_d    = state_q;
      rsp_data_d = rsp_data_q;
      rf_w_d     = 1'b0;
      rf_wdata_d = rf_wdata_q;
      rf_addr_d  = rf_addr_q;
      write_d    = write_q;
`ifdef REGS_VERIFY_EN
      rsp_err_d  = rsp_err_q;
`endif
      case (state_q)
         IDLE: begin
            // Port values are loaded at acceptance so they are already driven during ISSUE
            if (bus.req_valid && req_ready_q) begin
               state_d    = ISSUE;
               write_d    = bus.req_write;
               rf_w_d     = bus.req_write;
               rf_addr_d  = bus.req_addr;
               rf_wdata_d = bus.req_wdata;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (write_q) begin
`ifdef REGS_VERIFY_EN
               state_d = VREAD;
`else
               state_d    = RESP;
               rsp_data_d = rf_wdata_q;
`endif
            end else begin
               state_d = CAPT;
            end
         end
         VREAD: state_d = CAPT;
         CAPT: begin
            state_d    = RESP;
            rsp_data_d = bus.rf_rdata;
`ifdef REGS_VERIFY_EN
            rsp_err_d  = write_q && (bus.rf_rdata != rf_wdata_q);
`endif
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= {n{1'b0}};
         rf_w_q      <= 1'b0;
         rf_wdata_q  <= {n{1'b0}};
         rf_addr_q   <= 1'b0;
         write_q     <= 1'b0;
`ifdef REGS_VERIFY_EN
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rf_w_q      <= rf_w_d;
         rf_wdata_q  <= rf_wdata_d;
         rf_addr_q   <= rf_addr_d;
         write_q     <= write_d;
`ifdef REGS_VERIFY_EN
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rf_w      = rf_w_q;
   assign bus.rf_wdata  = rf_wdata_q;
   assign bus.rf_addr   = rf_addr_q;
`ifdef REGS_VERIFY_EN
   assign bus.rsp_err   = rsp_err_q;
`else
   assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_regs_port_ctrl.sv
// Self-checking bench for regs_port_ctrl: directed steps plus random traffic against a
// model register file and a spec-level scoreboard (works with or without REGS_VERIFY_EN).
module tb_regs_port_ctrl;
   localparam int N = 8;
`ifdef REGS_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic clk = 1'b0;
   logic n_reset;
   always #5 clk = ~clk;

   regs_port_ctrl_if #(.n(N)) bus ();
   regs_port_ctrl #(.n(N)) dut (.clk(clk), .n_reset(n_reset), .bus(bus));

   // Model register file: registered read, read-during-write returns old data
   logic [N-1:0] rf_mem [2] = '{default: '0};
   logic [N-1:0] rf_q = '0;
   logic         stuck0 = 1'b0;
   always @(posedge clk) begin
      if (bus.rf_w) rf_mem[bus.rf_addr] <= bus.rf_wdata;
      rf_q <= rf_mem[bus.rf_addr];
   end
   assign bus.rf_rdata = stuck0 ? (rf_q & ~8'h01) : rf_q;

   int checks = 0;
   int errors = 0;
   logic [N-1:0] ref_mem [2] = '{default: '0};
   logic [N-1:0] exp_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(posedge clk); @(negedge clk); n++;
      end
      chk({tag, "_req_ready"}, bus.req_ready, 1);
   endtask

   // One request from acceptance up to the first cycle of its response
   task automatic issue(input logic wr, input logic a, input logic [N-1:0] wd, input string tag);
      int lat, wcnt, exp_lat;
      logic [N-1:0] mask, exp_err;
      mask = stuck0 ? 8'hFE : 8'hFF;
      wait_ready(tag);
      bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = wd;
      @(posedge clk); @(negedge clk);
      bus.req_valid = 1'b0;
      chk({tag, "_issue_rf_w"}, bus.rf_w, wr);
      chk({tag, "_issue_addr"}, bus.rf_addr, a);
      if (wr) chk({tag, "_issue_wdata"}, bus.rf_wdata, wd);
      chk({tag, "_busy_ready"}, bus.req_ready, 0);
      if (wr) begin
         ref_mem[a] = wd;
         exp_lat  = VERIFY ? 4 : 2;
         exp_data = VERIFY ? (wd & mask) : wd;
         exp_err  = (VERIFY && ((wd & mask) != wd)) ? 8'd1 : 8'd0;
      end else begin
         exp_lat  = 3;
         exp_data = ref_mem[a] & mask;
         exp_err  = 8'd0;
      end
      lat = 1;
      wcnt = (bus.rf_w === 1'b1) ? 1 : 0;
      while (bus.rsp_valid !== 1'b1 && lat < 16) begin
         @(posedge clk); @(negedge clk); lat++;
         if (bus.rf_w === 1'b1) wcnt++;
      end
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 1);
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_rf_w_cycles"}, wcnt, wr ? 1 : 0);
      chk({tag, "_rsp_data"}, bus.rsp_data, exp_data);
      chk({tag, "_rsp_err"}, bus.rsp_err, exp_err);
   endtask

   // Hold the response for 'hold' cycles, then accept it
   task automatic complete(input int hold, input string tag);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); @(negedge clk);
         chk({tag, "_hold_valid"}, bus.rsp_valid, 1);
         chk({tag, "_hold_data"}, bus.rsp_data, exp_data);
         chk({tag, "_hold_ready"}, bus.req_ready, 0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk({tag, "_done_valid"}, bus.rsp_valid, 0);
      chk({tag, "_done_ready"}, bus.req_ready, 1);
   endtask

   initial begin
      int highs, last, wseen;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 1'b0;
      bus.req_wdata = '0; bus.rsp_ready = 1'b0;
      n_reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_rf_w", bus.rf_w, 0);
      chk("rst_rf_wdata", bus.rf_wdata, 0);
      chk("rst_rf_addr", bus.rf_addr, 0);
      n_reset = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("rst_release_ready", bus.req_ready, 1);

      issue(1'b1, 1'b1, 8'hA5, "wr1_a5"); complete(0, "wr1_a5");
      issue(1'b1, 1'b0, 8'h3C, "wr0_3c"); complete(0, "wr0_3c");
      issue(1'b0, 1'b0, 8'h00, "rd0");    complete(0, "rd0");
      issue(1'b0, 1'b1, 8'h00, "rd1");

      // Response held for 5 cycles while a new read is already presented
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 1'b0;
      complete(5, "rd1_hold");
      issue(1'b0, 1'b0, 8'h00, "rd0_pend"); complete(0, "rd0_pend");

      // Reset during the ISSUE cycle of a read
      wait_ready("rst_mid");
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.req_valid = 1'b0; n_reset = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rst_mid_valid", bus.rsp_valid, 0);
      chk("rst_mid_ready", bus.req_ready, 0);
      chk("rst_mid_rf_w", bus.rf_w, 0);
      chk("rst_mid_data", bus.rsp_data, 0);
      n_reset = 1'b1;
      @(posedge clk); @(negedge clk);
      issue(1'b0, 1'b1, 8'h00, "rd1_after_rst"); complete(0, "rd1_after_rst");

      // Write all-ones with a healthy and then a stuck-at-0 bit 0 register file
      issue(1'b1, 1'b0, 8'hFF, "wr_ff"); complete(0, "wr_ff");
      stuck0 = 1'b1;
      issue(1'b1, 1'b1, 8'hFF, "wr_ff_stuck"); complete(1, "wr_ff_stuck");
      issue(1'b0, 1'b1, 8'h00, "rd_stuck"); complete(0, "rd_stuck");
      stuck0 = 1'b0;

      // Back-to-back reads with rsp_ready held high
      wait_ready("b2b");
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 1'b0; bus.rsp_ready = 1'b1;
      highs = 0; last = -1; wseen = 0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); @(negedge clk);
         if (bus.rf_w === 1'b1) wseen++;
         if (bus.rsp_valid === 1'b1) begin
            if (last >= 0) chk("b2b_spacing", i - last, 4);
            chk("b2b_data", bus.rsp_data, ref_mem[0]);
            last = i; highs++;
         end
      end
      bus.req_valid = 1'b0;
      chk("b2b_count", highs, 4);
      chk("b2b_rf_w", wseen, 0);
      repeat (4) begin @(posedge clk); @(negedge clk); end
      bus.rsp_ready = 1'b0;

      // Random traffic against the scoreboard
      for (int k = 0; k < 40; k++) begin
         stuck0 = ($urandom_range(0, 4) == 0);
         issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), "rnd");
         complete($urandom_range(0, 3), "rnd");
      end
      stuck0 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/regs_port_ctrl.md
# regs_port_ctrl

Request-driven initiator for the picoMIPS two-entry general-purpose register file. It accepts single read or write requests from a host over a valid/ready handshake and drives the register file's write-enable, write-data and address port. It accounts for the register file's registered read, where data appears one clock after the address and a write cycle returns the old value. It returns one response per request over a second valid/ready handshake and sits between debug/test logic and the register file.

## Interface
- n, default 8, data bus width; must match the register file's data width.
- clk  input  1  system clock; all state changes on its rising edge.
- n_reset  input  1  reset, synchronous, active-low.
- req_valid  input  1  host request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  1  register index, 0 or 1.
- req_wdata  input  n  write data; ignored for reads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  host accepts response.
- rsp_data  output  n  read data, or written data for a write.
- rsp_err  output  1  write-verify mismatch; 0 unless REGS_VERIFY_EN.
- rf_w  output  1  register file write enable.
- rf_wdata  output  n  register file write data.
- rf_addr  output  1  register file address, used for both read and write.
- rf_rdata  input  n  register file registered read data.

## Operation
- States are IDLE, ISSUE, VREAD, CAPT and RESP. All outputs are registered or decoded from state.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch write, addr and wdata, then go to ISSUE.
- ISSUE (one cycle):
  - rf_addr=latched addr and rf_wdata=latched wdata.
  - rf_w=1 for a write, else 0.
  - A read goes to CAPT.
  - A write goes to RESP with rsp_data=wdata and rsp_err=0, or to VREAD when REGS_VERIFY_EN.
- VREAD (one cycle): rf_w=0, rf_addr held. Next state is CAPT.
- CAPT (one cycle):
  - rsp_data<=rf_rdata.
  - When verifying, rsp_err<=(rf_rdata!=latched wdata).
  - Next state is RESP.
- RESP:
  - rsp_valid=1, with rsp_data and rsp_err stable.
  - On rsp_ready, go to IDLE.
  - No new request is accepted until then, so at most one request is outstanding.
- rf_w is high only in a write ISSUE cycle.
- rf_addr and rf_wdata hold their last value outside ISSUE and VREAD, which keeps rf_rdata stable.
- The block never reads in the same cycle as a write. Read-during-write old data is never returned.
- Reset mid-operation:
  - Returns to IDLE and discards any pending response.
  - Register file contents are not reset. A write already issued persists.

## Timing
- Reset values: req_ready=0 during reset and 1 in the first cycle after reset. rsp_valid=0, rsp_data=0, rsp_err=0, rf_w=0, rf_wdata=0, rf_addr=0.
- Latency from the handshake edge to rsp_valid high:
  - read: 3 cycles;
  - write: 2 cycles;
  - verified write: 4 cycles.
- rsp_ready held high gives back-to-back throughput: read one request per 4 cycles, write one per 3.
- rsp_valid is not combinationally dependent on rsp_ready. rsp_ready while rsp_valid=0 is ignored.
- req_valid while not in IDLE is ignored; the host holds it until req_ready.

## Configuration
- REGS_VERIFY_EN defined: every write is followed by a VREAD readback of the same address. rsp_err=1 if the readback differs from the written data.
- Not defined: VREAD is never entered and rsp_err is tied 0.

## Test plan
- After reset, write addr 1 = 8'hA5 -> rf_w=1, rf_addr=1, rf_wdata=8'hA5 for exactly one cycle. rsp_valid arrives 2 cycles after the handshake with rsp_data=8'hA5.
- Write addr 0 = 8'h3C, then read addr 0 -> rsp_data=8'h3C, 3 cycles after the read handshake. A read of addr 1 returns its prior value.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stay stable and req_ready=0. A new request presented meanwhile is accepted only after the response completes.
- Assert n_reset=0 during ISSUE of a read -> next cycle rsp_valid=0, req_ready=0 and rf_w=0. After release, a new read completes normally.
- With REGS_VERIFY_EN and a model register file returning the correct data, write 8'hFF -> rsp_err=0 after 4 cycles. With a stuck-at-0 bit 0 injected -> rsp_err=1 and rsp_data=8'hFE.
- Back-to-back reads with rsp_ready=1 -> one response every 4 cycles. rf_w is never asserted.
